fifo_regs_flags: RTL and testbench

- Next-generation register-based synchronous FIFO: single clock, storage in a register array.
- Adds programmable almost-full/almost-empty thresholds, a fill-level output, and non-power-of-two depth.
- Adds sticky overflow/underflow error flags, so illegal accesses are dropped rather than fatal.
- Output mode is selectable: show-ahead or registered read.
- Used as the general buffering primitive between streaming blocks.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_ptr_wrap.sv | 32 +++
 rtl/fifo_regs_flags.sv | 201 ++++++++++++++++++++
 tb/tb_fifo_regs_flags.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the register-based FIFO family.
//   fifo_ptr_w(depth) : width of a read/write pointer, $clog2(depth)
//   fifo_cnt_w(depth) : width of the fill-level counter, $clog2(depth)+1
//                       (one extra bit so the value g_DEPTH itself fits)
//   FIFO_SHOW_AHEAD   : head word visible combinationally on the read port
//   FIFO_REG_OUT      : read data registered, one cycle after the read request
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int FIFO_SHOW_AHEAD = 0;
   localparam int FIFO_REG_OUT    = 1;

   // Depth 1 is rejected at elaboration, but keep the helper well defined.
   function automatic int fifo_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// -----------------------------------------------------------------------------
// fifo_ptr_wrap
// Circular pointer for a FIFO of arbitrary (not only power-of-two) depth.
// The pointer advances by one on i_adv and wraps from g_DEPTH-1 back to 0 by
// explicit comparison, so odd depths never address a non-existent entry.
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset, pointer -> 0
//   i_adv  : advance enable
//   o_ptr  : current pointer value, 0..g_DEPTH-1
// -----------------------------------------------------------------------------
module fifo_ptr_wrap #(
   parameter int g_DEPTH = 32,
   parameter int g_PTR_W = 5
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_adv,
   output logic [g_PTR_W-1:0] o_ptr
);

   localparam logic [g_PTR_W-1:0] c_LAST = g_PTR_W'(g_DEPTH - 1);
   localparam logic [g_PTR_W-1:0] c_ONE  = g_PTR_W'(1);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_ptr <= '0;
      end else if (i_adv) begin
         o_ptr <= (o_ptr == c_LAST) ? '0 : o_ptr + c_ONE;
      end
   end

endmodule

// File: rtl/fifo_regs_flags.sv
// -----------------------------------------------------------------------------
// fifo_regs_flags
// Single-clock FIFO with storage in a register array, fill level, programmable
// almost-full / almost-empty thresholds, sticky overflow/underflow flags and a
// selectable read mode (show-ahead or registered read).
//   i_clk          : clock, rising edge
//   i_rst          : asynchronous active-high reset
//   i_wr_en        : write request          i_wr_data : write data
//   i_rd_en        : read request           i_clr_err : clear sticky errors
//   o_rd_data      : read data              o_rd_valid: o_rd_data is valid
//   o_count        : number of stored entries
//   o_full/o_empty : count == g_DEPTH / count == 0
//   o_almost_full  : count >= g_AF_LEVEL
//   o_almost_empty : count <= g_AE_LEVEL
//   o_overflow     : sticky, a write was dropped
//   o_underflow    : sticky, a read was dropped
//
// Access semantics: a request is never back-pressured. A write is accepted
// when the FIFO is not full, or when it is full and a read is accepted in the
// same cycle. A read is accepted only when the FIFO is not empty; a write in
// the same cycle does not bypass into an empty FIFO. A request that is not
// accepted is dropped and sets the matching sticky error flag one cycle later.
// -----------------------------------------------------------------------------
module fifo_regs_flags
   import fifo_pkg::*;
#(
   parameter int g_WIDTH    = 8,
   parameter int g_DEPTH    = 32,
   parameter int g_AF_LEVEL = g_DEPTH - 4,
   parameter int g_AE_LEVEL = 4,
   parameter int g_REG_OUT  = 0
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_wr_en,
   input  logic [g_WIDTH-1:0]       i_wr_data,
   input  logic                     i_rd_en,
   input  logic                     i_clr_err,
   output logic [g_WIDTH-1:0]       o_rd_data,
   output logic                     o_rd_valid,
   output logic [$clog2(g_DEPTH):0] o_count,
   output logic                     o_full,
   output logic                     o_empty,
   output logic                     o_almost_full,
   output logic                     o_almost_empty,
   output logic                     o_overflow,
   output logic                     o_underflow
);

   localparam int PTR_W = fifo_ptr_w(g_DEPTH);
   localparam int CNT_W = fifo_cnt_w(g_DEPTH);

   localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(g_DEPTH);
   localparam logic [CNT_W-1:0] c_CNT_AF   = CNT_W'(g_AF_LEVEL);
   localparam logic [CNT_W-1:0] c_CNT_AE   = CNT_W'(g_AE_LEVEL);
   localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

   // ---------------------------------------------------------------- checks
   if (g_WIDTH < 1) begin : g_chk_width
      $error("fifo_regs_flags: g_WIDTH must be >= 1");
   end
   if (g_DEPTH < 2) begin : g_chk_depth
      $error("fifo_regs_flags: g_DEPTH must be >= 2");
   end
   if (g_AF_LEVEL < 1 || g_AF_LEVEL > g_DEPTH) begin : g_chk_af
      $error("fifo_regs_flags: g_AF_LEVEL must be in 1..g_DEPTH");
   end
   if (g_AE_LEVEL < 0 || g_AE_LEVEL > g_DEPTH - 1) begin : g_chk_ae
      $error("fifo_regs_flags: g_AE_LEVEL must be in 0..g_DEPTH-1");
   end
   if (g_REG_OUT != FIFO_SHOW_AHEAD && g_REG_OUT != FIFO_REG_OUT) begin : g_chk_mode
      $error("fifo_regs_flags: g_REG_OUT must be 0 or 1");
   end

   // ---------------------------------------------------------------- state
   logic [g_WIDTH-1:0] mem [g_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count_q;
   logic               overflow_q;
   logic               underflow_q;

   logic wr_acc;
   logic rd_acc;
   logic ovf_set;
   logic unf_set;

   // Status flags come from the count register only, so they change one
   // cycle after the causing edge and have no path from the request inputs.
   assign o_count        = count_q;
   assign o_full         = (count_q == c_CNT_FULL);
   assign o_empty        = (count_q == '0);
   assign o_almost_full  = (count_q >= c_CNT_AF);
   assign o_almost_empty = (count_q <= c_CNT_AE);
   assign o_overflow     = overflow_q;
   assign o_underflow    = underflow_q;

   assign rd_acc  = i_rd_en & ~o_empty;
   assign wr_acc  = i_wr_en & (~o_full | rd_acc);
   assign ovf_set = i_wr_en & ~wr_acc;
   assign unf_set = i_rd_en & ~rd_acc;

   // ---------------------------------------------------------------- pointers
   fifo_ptr_wrap #(
      .g_DEPTH (g_DEPTH),
      .g_PTR_W (PTR_W)
   ) u_wr_ptr (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_adv (wr_acc),
      .o_ptr (wr_ptr)
   );

   fifo_ptr_wrap #(
      .g_DEPTH (g_DEPTH),
      .g_PTR_W (PTR_W)
   ) u_rd_ptr (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_adv (rd_acc),
      .o_ptr (rd_ptr)
   );

   // ---------------------------------------------------------------- storage
   // Contents are not reset; count and pointers alone define what is valid.
   always_ff @(posedge i_clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= i_wr_data;
      end
   end

   // ---------------------------------------------------------------- count
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count_q <= '0;
      end else if (wr_acc && !rd_acc) begin
         count_q <= count_q + c_CNT_ONE;
      end else if (rd_acc && !wr_acc) begin
         count_q <= count_q - c_CNT_ONE;
      end
   end

   // ---------------------------------------------------------------- errors
   // A new error in the same cycle as i_clr_err keeps the flag set.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (ovf_set) begin
            overflow_q <= 1'b1;
         end else if (i_clr_err) begin
            overflow_q <= 1'b0;
         end
         if (unf_set) begin
            underflow_q <= 1'b1;
         end else if (i_clr_err) begin
            underflow_q <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------- read port
   if (g_REG_OUT == FIFO_REG_OUT) begin : g_reg_out
      logic [g_WIDTH-1:0] rd_data_q;
      logic               rd_valid_q;

      // Data is captured on the accepting edge and held afterwards; valid is
      // a one-cycle pulse per accepted read.
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
               rd_data_q <= mem[rd_ptr];
            end
         end
      end

      assign o_rd_data  = rd_data_q;
      assign o_rd_valid = rd_valid_q;
   end else begin : g_show_ahead
      assign o_rd_data  = mem[rd_ptr];
      assign o_rd_valid = ~o_empty;
   end

   // ---------------------------------------------------------------- sim notes
`ifndef SYNTHESIS
   always @(posedge i_clk) begin
      if (!i_rst && ovf_set && !overflow_q) begin
         $warning("fifo_regs_flags: write dropped while full, overflow flag set");
      end
      if (!i_rst && unf_set && !underflow_q) begin
         $warning("fifo_regs_flags: read dropped while empty, underflow flag set");
      end
   end
`endif

endmodule

// File: tb/tb_fifo_regs_flags.sv
// -----------------------------------------------------------------------------
// tb_fifo_regs_flags
// Directed bench for fifo_regs_flags: one show-ahead instance (depth 5,
// AF=4, AE=1) and one registered-read instance with the same geometry.
// -----------------------------------------------------------------------------
module tb_fifo_regs_flags;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- show-ahead dut
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic       rd_en = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic [3:0] count;
   logic       full, empty, almost_full, almost_empty, overflow, underflow;

   fifo_regs_flags #(
      .g_WIDTH (8), .g_DEPTH (5), .g_AF_LEVEL (4), .g_AE_LEVEL (1), .g_REG_OUT (0)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_wr_en        (wr_en),
      .i_wr_data      (wr_data),
      .i_rd_en        (rd_en),
      .i_clr_err      (clr_err),
      .o_rd_data      (rd_data),
      .o_rd_valid     (rd_valid),
      .o_count        (count),
      .o_full         (full),
      .o_empty        (empty),
      .o_almost_full  (almost_full),
      .o_almost_empty (almost_empty),
      .o_overflow     (overflow),
      .o_underflow    (underflow)
   );

   // ---------------------------------------------------------------- registered-read dut
   logic       r_wr_en = 1'b0;
   logic [7:0] r_wr_data = '0;
   logic       r_rd_en = 1'b0;
   logic       r_clr_err = 1'b0;
   logic [7:0] r_rd_data;
   logic       r_rd_valid;
   logic [3:0] r_count;
   logic       r_full, r_empty, r_almost_full, r_almost_empty, r_overflow, r_underflow;

   fifo_regs_flags #(
      .g_WIDTH (8), .g_DEPTH (5), .g_AF_LEVEL (4), .g_AE_LEVEL (1), .g_REG_OUT (1)
   ) dut_r (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_wr_en        (r_wr_en),
      .i_wr_data      (r_wr_data),
      .i_rd_en        (r_rd_en),
      .i_clr_err      (r_clr_err),
      .o_rd_data      (r_rd_data),
      .o_rd_valid     (r_rd_valid),
      .o_count        (r_count),
      .o_full         (r_full),
      .o_empty        (r_empty),
      .o_almost_full  (r_almost_full),
      .o_almost_empty (r_almost_empty),
      .o_overflow     (r_overflow),
      .o_underflow    (r_underflow)
   );

   // ---------------------------------------------------------------- scoreboard
   logic [7:0] exp_q[$];
   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- drivers
   // Inputs change at the falling edge; outputs are sampled 1 ns after the
   // rising edge, when the step returns.
   task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
      @(negedge clk);
      wr_en = wr; wr_data = d; rd_en = rd; clr_err = clr;
      @(posedge clk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
   endtask

   task automatic step_r(input logic wr, input logic [7:0] d, input logic rd);
      @(negedge clk);
      r_wr_en = wr; r_wr_data = d; r_rd_en = rd;
      @(posedge clk);
      #1;
      r_wr_en = 1'b0; r_rd_en = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      step(1'b1, d, 1'b0, 1'b0);
      exp_q.push_back(d);
   endtask

   // Show-ahead: the head word is checked before the read edge pops it.
   task automatic pop_check(input string tag);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_qempty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_valid"}, 32'(rd_valid), 32'd1);
         check({tag, "_data"}, 32'(rd_data), 32'(e));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   // ---------------------------------------------------------------- test body
   logic [4:0] ae_tab   = 5'b00001;  // bit k-1: almost_empty after write k
   logic [4:0] af_tab   = 5'b11000;
   logic [4:0] full_tab = 5'b10000;

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // reset state
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_ae", 32'(almost_empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_af", 32'(almost_full), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_unf", 32'(underflow), 32'd0);
      check("rst_valid", 32'(rd_valid), 32'd0);
      check("rst_r_valid", 32'(r_rd_valid), 32'd0);
      check("rst_r_data", 32'(r_rd_data), 32'd0);

      // fill 0x11..0x55 and watch the flags step
      for (int k = 1; k <= 5; k++) begin
         push(8'(k * 8'h11));
         check($sformatf("fill%0d_count", k), 32'(count), 32'(k));
         check($sformatf("fill%0d_ae", k), 32'(almost_empty), 32'(ae_tab[k-1]));
         check($sformatf("fill%0d_af", k), 32'(almost_full), 32'(af_tab[k-1]));
         check($sformatf("fill%0d_full", k), 32'(full), 32'(full_tab[k-1]));
         check($sformatf("fill%0d_empty", k), 32'(empty), 32'd0);
      end
      for (int k = 1; k <= 5; k++) pop_check($sformatf("drain%0d", k));
      check("drain_empty", 32'(empty), 32'd1);
      check("drain_count", 32'(count), 32'd0);

      // wrap: 3 in / 3 out, four rounds, pointers cross 4 -> 0
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 3; i++) push(8'(8'h60 + r * 3 + i));
         check($sformatf("wrap%0d_count3", r), 32'(count), 32'd3);
         for (int i = 0; i < 3; i++) pop_check($sformatf("wrap%0d_rd%0d", r, i));
         check($sformatf("wrap%0d_count0", r), 32'(count), 32'd0);
      end

      // full with simultaneous write+read, then a dropped write
      for (int i = 0; i < 5; i++) push(8'(8'hA0 + i));
      check("fullrw_head", 32'(rd_data), 32'hA0);
      step(1'b1, 8'hAA, 1'b1, 1'b0);
      void'(exp_q.pop_front());
      exp_q.push_back(8'hAA);
      check("fullrw_count", 32'(count), 32'd5);
      check("fullrw_ovf", 32'(overflow), 32'd0);
      check("fullrw_head2", 32'(rd_data), 32'hA1);
      step(1'b1, 8'hBB, 1'b0, 1'b0);
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_count", 32'(count), 32'd5);
      for (int k = 0; k < 5; k++) pop_check($sformatf("ovf_drain%0d", k));
      check("ovf_sticky", 32'(overflow), 32'd1);

      // empty with simultaneous write+read: no bypass
      step(1'b1, 8'h5A, 1'b1, 1'b0);
      exp_q.push_back(8'h5A);
      check("emptyrw_unf", 32'(underflow), 32'd1);
      check("emptyrw_count", 32'(count), 32'd1);
      pop_check("emptyrw_rd");
      // clear colliding with a new underflow: the set wins
      step(1'b0, 8'h00, 1'b1, 1'b1);
      check("clrset_unf", 32'(underflow), 32'd1);
      check("clrset_ovf", 32'(overflow), 32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("clr_unf", 32'(underflow), 32'd0);
      check("clr_ovf", 32'(overflow), 32'd0);

      // registered read mode
      step_r(1'b1, 8'h01, 1'b0);
      step_r(1'b1, 8'h02, 1'b0);
      check("reg_pre_valid", 32'(r_rd_valid), 32'd0);
      step_r(1'b0, 8'h00, 1'b1);
      check("reg_n1_valid", 32'(r_rd_valid), 32'd1);
      check("reg_n1_data", 32'(r_rd_data), 32'h01);
      step_r(1'b0, 8'h00, 1'b0);
      check("reg_n2_valid", 32'(r_rd_valid), 32'd0);
      check("reg_n2_data", 32'(r_rd_data), 32'h01);
      step_r(1'b0, 8'h00, 1'b1);
      check("reg_rd2_data", 32'(r_rd_data), 32'h02);
      check("reg_rd2_valid", 32'(r_rd_valid), 32'd1);
      check("reg_count", 32'(r_count), 32'd0);

      // asynchronous reset mid-stream
      step(1'b0, 8'h00, 1'b1, 1'b0);  // empty read -> underflow
      push(8'hC1); push(8'hC2); push(8'hC3);
      check("arst_pre_count", 32'(count), 32'd3);
      check("arst_pre_unf", 32'(underflow), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("arst_count", 32'(count), 32'd0);
      check("arst_empty", 32'(empty), 32'd1);
      check("arst_unf", 32'(underflow), 32'd0);
      check("arst_ovf", 32'(overflow), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      push(8'h77);
      check("arst_post_count", 32'(count), 32'd1);
      pop_check("arst_post_rd");
      check("arst_post_empty", 32'(empty), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
